// File: rtl/fpdiv_arbiter_if.sv
// Requester and divider handshake bundle for fpdiv_arbiter.
// The arbiter connects through the slave modport; requesters and the divider sit on the master side.
interface fpdiv_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_start;
  logic [NREQ*N-1:0] req_in;
  logic [NREQ-1:0]   req_busy;
  logic [NREQ-1:0]   req_done;
  logic [NREQ-1:0]   req_err;
  logic [N-1:0]      req_ans;
  logic              div_start;
  logic [N-1:0]      div_in;
  logic [N-1:0]      div_ans;
  logic              div_done;
  logic              div_rst;

  modport slave (
    input  req_start, req_in, div_ans, div_done,
    output req_busy, req_done, req_err, req_ans, div_start, div_in, div_rst
  );

  modport master (
    output req_start, req_in, div_ans, div_done,
    input  req_busy, req_done, req_err, req_ans, div_start, div_in, div_rst
  );
endinterface

// File: rtl/fpdiv_arbiter.sv
// Round-robin sharing of one fpdiv_clk reciprocal unit among NREQ requesters, with a hang watchdog.
// FPDIV_ARB_ZERO_GUARD_EN: zero-magnitude operands bypass the divider and return saturated with err.
module fpdiv_arbiter #(
  parameter int N    = 32,
  parameter int Q    = 16,
  parameter int NREQ = 4,
  parameter int TMO  = 200
) (
  input  logic          clk,
  input  logic          rst,
  fpdiv_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fpdiv_arbiter: NREQ must be 2..8");
  end
  if (TMO < 1 || TMO > 255) begin : g_bad_tmo
    $error("fpdiv_arbiter: TMO must be 1..255");
  end
  if (Q >= N) begin : g_bad_q
    $error("fpdiv_arbiter: Q must be below N");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RECOVER, DELIVER} state_t;

  state_t            state;
  logic [N-1:0]      opnd [NREQ];
  logic [NREQ-1:0]   pending;
  logic [NREQ-1:0]   pend_nxt;
  logic [NREQ-1:0]   svc_mask;
  logic [NREQ-1:0]   grant_oh;
  logic [NREQ-1:0]   win_oh;
  logic [PW-1:0]     last;
  logic [PW-1:0]     grant;
  logic [PW-1:0]     win;
  logic [PW-1:0]     cand;
  logic              found;
  logic              zero_op;
  logic [7:0]        wd;
  logic [N-1:0]      result;
  logic              err;
  logic [N-1:0]      win_opnd;
  int unsigned       idx;

  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (int'(last) + k) % NREQ;
      cand = PW'(idx);
      if (!found && pending[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_opnd = opnd[win];
  assign win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant;

`ifdef FPDIV_ARB_ZERO_GUARD_EN
  assign zero_op = ~|win_opnd[N-2:0];
`else
  assign zero_op = 1'b0;
`endif

  // Busy is precomputed from next-state knowledge so it drops in the same cycle req_done rises.
  always_comb begin
    pend_nxt = pending;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (bus.req_start[i] && !bus.req_busy[i]) pend_nxt[i] = 1'b1;
    end
    if (state == IDLE && found) pend_nxt = pend_nxt & ~win_oh;
    case (state)
      IDLE:                 svc_mask = found ? win_oh : '0;
      ISSUE, WAIT, RECOVER: svc_mask = grant_oh;
      default:              svc_mask = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      pending       <= '0;
      last          <= PW'(NREQ - 1);
      grant         <= '0;
      wd            <= '0;
      result        <= '0;
      err           <= 1'b0;
      bus.req_busy  <= '0;
      bus.req_done  <= '0;
      bus.req_err   <= '0;
      bus.req_ans   <= '0;
      bus.div_start <= 1'b0;
      bus.div_in    <= '0;
      bus.div_rst   <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) opnd[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (bus.req_start[i] && !bus.req_busy[i]) opnd[i] <= bus.req_in[i*N +: N];
      end
      pending       <= pend_nxt;
      bus.req_busy  <= pend_nxt | svc_mask;
      bus.req_done  <= '0;
      bus.req_err   <= '0;
      bus.div_start <= 1'b0;
      bus.div_rst   <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= win;
            last       <= win;
            bus.div_in <= win_opnd;
            if (zero_op) begin
              result <= {win_opnd[N-1], {(N-1){1'b1}}};
              err    <= 1'b1;
              state  <= DELIVER;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.div_start <= 1'b1;
          wd            <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          // wd==0 is the first WAIT cycle, where a stale done from the previous job may still be visible.
          if (wd != '0 && bus.div_done) begin
            result <= bus.div_ans;
            err    <= 1'b0;
            state  <= DELIVER;
          end else if (wd == 8'(TMO - 1)) begin
            state <= RECOVER;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        RECOVER: begin
          bus.div_rst <= 1'b0;
          result      <= {opnd[grant][N-1], {(N-1){1'b1}}};
          err         <= 1'b1;
          state       <= DELIVER;
        end
        DELIVER: begin
          bus.req_done <= grant_oh;
          bus.req_err  <= err ? grant_oh : '0;
          bus.req_ans  <= result;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Scoreboard bench for fpdiv_arbiter with a behavioural fixed-latency reciprocal divider.
module tb_fpdiv_arbiter;
  localparam int N = 32;
  localparam int NREQ = 4;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpdiv_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  fpdiv_arbiter #(.N(N), .Q(16), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] ans;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_rstlow = 0;
  int n_done [NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Divider model: 5-cycle latency, zero magnitude never completes, div_rst clears it.
  function automatic logic [31:0] recip(input logic [31:0] x);
    logic [63:0] q;
    q = 64'h1_0000_0000 / {33'd0, x[30:0]};
    if (q > 64'h7FFF_FFFF) q = 64'h7FFF_FFFF;
    return {x[31], q[30:0]};
  endfunction

  logic [31:0] m_op;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (!bus.div_rst) begin
      m_busy       <= 1'b0;
      bus.div_done <= 1'b0;
    end else begin
      bus.div_done <= 1'b0;
      if (bus.div_start) begin
        m_busy <= 1'b1;
        m_op   <= bus.div_in;
        m_cnt  <= 5;
      end else if (m_busy && m_op[30:0] != 31'd0) begin
        if (m_cnt == 1) begin
          m_busy       <= 1'b0;
          bus.div_done <= 1'b1;
          bus.div_ans  <= recip(m_op);
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) n_done[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.div_start) n_start++;
        if (!bus.div_rst) n_rstlow++;
        if (m_busy && bus.div_rst) chk("div_in_stable", bus.div_in, m_op);
        if (bus.req_done != '0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=%b required=none", bus.req_done);
          end else begin
            exp_t e;
            logic [31:0] oh;
            e  = sb.pop_front();
            oh = 32'd1 << e.idx;
            chk("done_onehot", 32'(bus.req_done), oh);
            chk("ans", bus.req_ans, e.ans);
            chk("err", 32'(bus.req_err), e.err ? oh : 32'd0);
            n_done[e.idx]++;
          end
        end
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] op);
    @(negedge clk);
    bus.req_start[i] = 1'b1;
    bus.req_in[i*N +: N] = op;
    @(negedge clk);
    bus.req_start = '0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((sb.size() != 0 || bus.req_busy != '0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", 32'(c >= budget), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic push(input int i, input logic [31:0] ans, input logic err);
    exp_t e;
    e.idx = i;
    e.ans = ans;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(bus.req_busy), 32'd0);
    chk("rst_done", 32'(bus.req_done), 32'd0);
    chk("rst_err", 32'(bus.req_err), 32'd0);
    chk("rst_ans", bus.req_ans, 32'd0);
    chk("rst_div_start", 32'(bus.div_start), 32'd0);
    chk("rst_div_in", bus.div_in, 32'd0);
    chk("rst_div_rst", 32'(bus.div_rst), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, r0, d0, c;
    bus.req_start = '0;
    bus.req_in    = '0;

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b1;
    @(negedge clk);
    chk("div_rst_release", 32'(bus.div_rst), 32'd1);

    // Single request, 2.0 on requester 0, with latency checks.
    s0 = n_start;
    push(0, 32'h0000_8000, 1'b0);
    issue(0, 32'h0002_0000);
    chk("busy_after_start", 32'(bus.req_busy), 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("div_start_latency", 32'(bus.div_start), 32'd1);
    chk("div_in_load", bus.div_in, 32'h0002_0000);
    wait_idle(200);
    chk("single_div_start_count", n_start - s0, 1);

    // Negative operand on requester 2.
    push(2, 32'h8000_4000, 1'b0);
    issue(2, 32'h8004_0000);
    wait_idle(200);

    // Second start while busy is dropped.
    d0 = n_done[3];
    push(3, 32'h0001_0000, 1'b0);
    issue(3, 32'h0001_0000);
    chk("busy3_before_drop", 32'(bus.req_busy[3]), 32'd1);
    bus.req_start[3] = 1'b1;
    bus.req_in[3*N +: N] = 32'h0004_0000;
    @(negedge clk);
    bus.req_start = '0;
    wait_idle(200);
    chk("drop_done_count", n_done[3] - d0, 1);

    // Fairness: all four at once, requester 0 re-requests on its done cycle.
    push(0, 32'h0001_0000, 1'b0);
    push(1, 32'h0000_8000, 1'b0);
    push(2, 32'h0000_4000, 1'b0);
    push(3, 32'h0002_0000, 1'b0);
    @(negedge clk);
    bus.req_start = 4'b1111;
    bus.req_in = {32'h0000_8000, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000};
    @(negedge clk);
    bus.req_start = '0;
    c = 0;
    while (!bus.req_done[0] && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("fair_done0_timeout", 32'(c >= 500), 32'd0);
    chk("busy0_clear_on_done", 32'(bus.req_busy[0]), 32'd0);
    push(0, 32'h0001_0000, 1'b0);
    bus.req_start[0] = 1'b1;
    bus.req_in[0 +: N] = 32'h0001_0000;
    @(negedge clk);
    bus.req_start = '0;
    wait_idle(1000);

    // Zero operand on requester 1, then a normal request.
    s0 = n_start;
    r0 = n_rstlow;
    push(1, 32'h7FFF_FFFF, 1'b1);
    issue(1, 32'h0000_0000);
    wait_idle(1000);
`ifdef FPDIV_ARB_ZERO_GUARD_EN
    chk("zero_div_start_count", n_start - s0, 0);
    chk("zero_div_rst_cycles", n_rstlow - r0, 0);
`else
    chk("zero_div_start_count", n_start - s0, 1);
    chk("zero_div_rst_cycles", n_rstlow - r0, 1);
`endif
    push(1, 32'h0000_8000, 1'b0);
    issue(1, 32'h0002_0000);
    wait_idle(200);

    // Reset during WAIT discards the job.
    s0 = n_start;
    issue(1, 32'h0002_0000);
    c = 0;
    while (n_start == s0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("abort_div_start_timeout", 32'(c >= 50), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_busy_clear", 32'(bus.req_busy), 32'd0);
    push(2, 32'h0002_0000, 1'b0);
    issue(2, 32'h0000_8000);
    wait_idle(200);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
